keypad_scanner: RTL and testbench

Input-side counterpart to the seven-segment display driver. It scans a 4x4 active-low matrix keypad by strobing columns, debounces the sampled matrix, and decodes a single pressed key into a 4-bit hex code. Each accepted key is delivered on a valid/ready handshake and shifted into an 8-digit register whose outputs feed the display's `bcds` input directly.

---
 rtl/keypad_scanner_pkg.sv | 44 ++++
 rtl/keypad_scanner_if.sv | 26 ++
 rtl/keypad_scanner_scan_tick_gen.sv | 27 ++
 rtl/keypad_scanner.sv | 189 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
// Key codes are the snapshot bit index {col, row}.
package keypad_pkg;

  localparam int KEY_COLS = 4;
  localparam int KEY_ROWS = 4;
  localparam int DIGITS   = 8;

  typedef logic [3:0] key_code_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CANDIDATE = 2'd1,
    PRESSED   = 2'd2
  } key_state_e;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    KEY   = 2'd1,
    GHOST = 2'd2
  } sweep_e;

  function automatic logic [4:0] count_ones(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

  // Only meaningful when exactly one bit is set.
  function automatic key_code_t first_set(input logic [15:0] v);
    key_code_t idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) begin
        idx = key_code_t'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key event handshake plus the digit history that feeds the display driver.
interface keypad_scanner_if;
  import keypad_pkg::*;

  key_code_t               key_code;
  logic                    key_valid;
  logic                    key_ready;
  logic                    key_overrun;
  logic [DIGITS-1:0][3:0]  digits;

  modport master (
    output key_code,
    output key_valid,
    output key_overrun,
    output digits,
    input  key_ready
  );

  modport slave (
    input  key_code,
    input  key_valid,
    input  key_overrun,
    input  digits,
    output key_ready
  );
endinterface

// File: rtl/keypad_scanner_scan_tick_gen.sv
// Free-running divider: one-cycle tick every SCAN_DIV clocks.
// Shared by any slow-strobe input scanner.
module scan_tick_gen #(
  parameter int SCAN_DIV = 100_000
) (
  input  logic clock_100Mhz,
  input  logic reset,
  output logic tick
);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] count_r;

  // Divider counter, wraps silently at SCAN_DIV-1
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (count_r == LAST) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + CW'(1);
    end
  end

  assign tick = (count_r == LAST);
endmodule

// File: rtl/keypad_scanner.sv
// Scans a 4x4 active-low keypad, debounces whole sweeps and delivers decoded
// hex keys on a valid/ready handshake plus an 8-digit history register.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100_000,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic             clock_100Mhz,
  input  logic             reset,
  input  logic [3:0]       row_n,
  output logic [3:0]       col_n,
  keypad_scanner_if.master key
);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_SCANS - 1);

  logic [3:0]             row_meta_r;
  logic [3:0]             row_sync_r;
  logic                   tick_s;
  logic [1:0]             col_r;
  logic [3:0]             col_n_r;
  logic [15:0]            snap_r;
  logic [15:0]            snap_full_s;
  logic [4:0]             ones_s;
  logic                   sweep_done_s;
  sweep_e                 sweep_s;
  key_code_t              code_s;

  key_state_e             state_r, state_next_s;
  key_code_t              cand_r, cand_next_s;
  logic [DW-1:0]          cnt_r, cnt_next_s;
  logic [DW-1:0]          rel_r, rel_next_s;
  logic                   emit_s;

  key_code_t              key_code_r;
  logic                   key_valid_r;
  logic                   key_overrun_r;
  logic [DIGITS-1:0][3:0] digits_r;
  logic                   accept_s;

  // Two-flop synchronizer for the asynchronous row lines
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      row_meta_r <= 4'hF;
      row_sync_r <= 4'hF;
    end else begin
      row_meta_r <= row_n;
      row_sync_r <= row_meta_r;
    end
  end

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .tick         (tick_s)
  );

  // Column strobe rotation and snapshot capture on each tick
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      col_r   <= 2'd0;
      col_n_r <= 4'b1110;
      snap_r  <= 16'h0000;
    end else if (tick_s) begin
      col_r   <= col_r + 2'd1;
      col_n_r <= {col_n_r[2:0], col_n_r[3]};
      snap_r  <= snap_full_s;
    end
  end

  // Decode includes the column being captured this cycle, so the result is
  // ready on the completing tick itself.
  always_comb begin
    snap_full_s = snap_r;
    snap_full_s[{col_r, 2'b00} +: 4] = ~row_sync_r;
    ones_s = count_ones(snap_full_s);
    code_s = first_set(snap_full_s);
    if (ones_s == 5'd0) begin
      sweep_s = NONE;
    end else if (ones_s == 5'd1) begin
      sweep_s = KEY;
    end else begin
      sweep_s = GHOST;
    end
  end

  assign sweep_done_s = tick_s && (col_r == 2'd3);

  // Debounce state register
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cand_r  <= 4'h0;
      cnt_r   <= '0;
      rel_r   <= '0;
    end else begin
      state_r <= state_next_s;
      cand_r  <= cand_next_s;
      cnt_r   <= cnt_next_s;
      rel_r   <= rel_next_s;
    end
  end

  // Debounce next-state, evaluated once per completed sweep
  always_comb begin
    state_next_s = state_r;
    cand_next_s  = cand_r;
    cnt_next_s   = cnt_r;
    rel_next_s   = rel_r;
    emit_s       = 1'b0;
    if (sweep_done_s) begin
      case (state_r)
        IDLE: begin
          if (sweep_s == KEY) begin
            state_next_s = CANDIDATE;
            cand_next_s  = code_s;
            cnt_next_s   = DW'(1);
          end else begin
            state_next_s = IDLE;
          end
        end
        CANDIDATE: begin
          if ((sweep_s == KEY) && (code_s == cand_r)) begin
            cnt_next_s = cnt_r + DW'(1);
            if (cnt_r == DB_LAST) begin
              emit_s       = 1'b1;
              state_next_s = PRESSED;
              rel_next_s   = '0;
            end else begin
              state_next_s = CANDIDATE;
            end
          end else begin
            state_next_s = IDLE;
            cnt_next_s   = '0;
          end
        end
        PRESSED: begin
          if (sweep_s == NONE) begin
            if (rel_r == DB_LAST) begin
              state_next_s = IDLE;
              rel_next_s   = '0;
              cnt_next_s   = '0;
            end else begin
              rel_next_s = rel_r + DW'(1);
            end
          end else begin
            rel_next_s = '0;
          end
        end
        default: begin
          state_next_s = IDLE;
          cnt_next_s   = '0;
          rel_next_s   = '0;
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  assign accept_s = key_valid_r && key.key_ready;

  // Event delivery: an accept on the same edge frees the slot for a new event
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      key_code_r    <= 4'h0;
      key_valid_r   <= 1'b0;
      key_overrun_r <= 1'b0;
      digits_r      <= '0;
    end else if (emit_s && (!key_valid_r || accept_s)) begin
      key_code_r    <= cand_r;
      key_valid_r   <= 1'b1;
      key_overrun_r <= 1'b0;
      digits_r      <= {digits_r[DIGITS-2:0], cand_r};
    end else if (emit_s) begin
      key_overrun_r <= 1'b1;
    end else if (accept_s) begin
      key_valid_r   <= 1'b0;
      key_overrun_r <= 1'b0;
    end
  end

  assign col_n           = col_n_r;
  assign key.key_code    = key_code_r;
  assign key.key_valid   = key_valid_r;
  assign key.key_overrun = key_overrun_r;
  assign key.digits      = digits_r;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=2
// (one sweep = 16 cycles) and a behavioural matrix keypad model.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int SD    = 4;
  localparam int DB    = 2;
  localparam int SWEEP = 4 * SD;

  typedef struct {
    logic       ready;
    logic [3:0] exp_col_n;
    logic       exp_valid;
    logic       exp_overrun;
  } vec_t;

  logic        clock_100Mhz = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [15:0] pressed = 16'h0000;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          vpulses = 0;
  logic        prev_valid = 1'b0;
  logic [3:0]  last_code = 4'h0;

  keypad_scanner_if kif();

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .row_n        (row_n),
    .col_n        (col_n),
    .key          (kif)
  );

  always #5 clock_100Mhz = ~clock_100Mhz;

  // Keypad matrix: a pressed key pulls its row low while its column is strobed
  always_comb begin
    row_n = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!col_n[c] && pressed[c*4+r]) begin
          row_n[r] = 1'b0;
        end
      end
    end
  end

  always @(posedge clock_100Mhz or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(negedge clock_100Mhz) begin
    prev_valid <= kif.key_valid;
    if (kif.key_valid && !prev_valid) begin
      vpulses   <= vpulses + 1;
      last_code <= kif.key_code;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock_100Mhz);
    reset = 1'b1;
    pressed = 16'h0000;
    kif.key_ready = 1'b0;
    repeat (2) @(negedge clock_100Mhz);
    reset = 1'b0;
  endtask

  task automatic align();
    @(negedge clock_100Mhz);
    while (cyc % SWEEP != 0) @(negedge clock_100Mhz);
  endtask

  task automatic idle(input int sweeps);
    repeat (sweeps * SWEEP) @(negedge clock_100Mhz);
  endtask

  task automatic press(input logic [15:0] mask, input int sweeps);
    align();
    pressed = mask;
    repeat (sweeps * SWEEP) @(negedge clock_100Mhz);
    pressed = 16'h0000;
  endtask

  vec_t       vecs[20];
  logic [3:0] col_pat[4];
  int         p;

  initial begin
    col_pat = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    for (int i = 0; i < 20; i++) begin
      vecs[i].ready       = i[0];
      vecs[i].exp_col_n   = col_pat[(i / 4) % 4];
      vecs[i].exp_valid   = 1'b0;
      vecs[i].exp_overrun = 1'b0;
    end
    kif.key_ready = 1'b0;

    // 1: column rotation and idle outputs, key_ready toggling is ignored
    do_reset();
    check("rst_code", kif.key_code, 4'h0);
    for (int i = 0; i < 20; i++) begin
      kif.key_ready = vecs[i].ready;
      check("s1_col_n", col_n, vecs[i].exp_col_n);
      check("s1_valid", kif.key_valid, vecs[i].exp_valid);
      check("s1_overrun", kif.key_overrun, vecs[i].exp_overrun);
      @(negedge clock_100Mhz);
    end
    check("s1_digits", kif.digits, 32'h0000_0000);

    // 2: key 6 held for 4 sweeps gives a single event
    kif.key_ready = 1'b1;
    p = vpulses;
    press(16'h0040, 4);
    idle(3);
    check("s2_pulses", vpulses - p, 32'd1);
    check("s2_code", last_code, 4'h6);
    check("s2_digit0", kif.digits[0], 4'h6);
    check("s2_digit1", kif.digits[1], 4'h0);
    check("s2_valid", kif.key_valid, 1'b0);

    // 3: a single-sweep press is rejected
    p = vpulses;
    press(16'h0008, 1);
    idle(2);
    check("s3_pulses", vpulses - p, 32'd0);
    check("s3_state", 32'(dut.state_r), 32'(IDLE));

    // 4: press-to-valid latency, then overrun while unconsumed
    do_reset();
    align();
    pressed = 16'h0020;
    repeat (2 * SWEEP - 1) @(negedge clock_100Mhz);
    check("s4_lat_early", kif.key_valid, 1'b0);
    @(negedge clock_100Mhz);
    check("s4_lat_valid", kif.key_valid, 1'b1);
    repeat (SWEEP) @(negedge clock_100Mhz);
    pressed = 16'h0000;
    idle(3);
    press(16'h0200, 3);
    idle(1);
    check("s4_valid", kif.key_valid, 1'b1);
    check("s4_code", kif.key_code, 4'h5);
    check("s4_overrun", kif.key_overrun, 1'b1);
    check("s4_digits", kif.digits, 32'h0000_0005);
    kif.key_ready = 1'b1;
    @(negedge clock_100Mhz);
    kif.key_ready = 1'b0;
    check("s4_acc_valid", kif.key_valid, 1'b0);
    check("s4_acc_overrun", kif.key_overrun, 1'b0);

    // 5: two keys at once is a ghost and never emits
    kif.key_ready = 1'b1;
    p = vpulses;
    press(16'h0404, 4);
    idle(1);
    check("s5_pulses", vpulses - p, 32'd0);
    check("s5_digits", kif.digits, 32'h0000_0005);

    // Emit and accept on the same edge: new event loads, no overrun
    kif.key_ready = 1'b0;
    press(16'h0080, 3);
    idle(3);
    check("bb_first_valid", kif.key_valid, 1'b1);
    check("bb_first_code", kif.key_code, 4'h7);
    align();
    pressed = 16'h0100;
    repeat (2 * SWEEP - 1) @(negedge clock_100Mhz);
    kif.key_ready = 1'b1;
    @(negedge clock_100Mhz);
    kif.key_ready = 1'b0;
    check("bb_valid", kif.key_valid, 1'b1);
    check("bb_code", kif.key_code, 4'h8);
    check("bb_overrun", kif.key_overrun, 1'b0);
    check("bb_digits", kif.digits, 32'h0000_0578);
    repeat (SWEEP) @(negedge clock_100Mhz);
    pressed = 16'h0000;
    idle(3);

    // 6: nine keys fill the history, then reset mid-press clears it
    do_reset();
    kif.key_ready = 1'b1;
    p = vpulses;
    for (int k = 1; k <= 9; k++) begin
      press(16'h0001 << k, 3);
      idle(3);
    end
    check("s6_pulses", vpulses - p, 32'd9);
    check("s6_digits", kif.digits, 32'h2345_6789);
    align();
    pressed = 16'h0400;
    repeat (20) @(negedge clock_100Mhz);
    #2 reset = 1'b1;
    #1;
    check("s6_rst_digits", kif.digits, 32'h0000_0000);
    check("s6_rst_valid", kif.key_valid, 1'b0);
    check("s6_rst_col_n", col_n, 4'b1110);
    check("s6_rst_overrun", kif.key_overrun, 1'b0);
    repeat (2) @(negedge clock_100Mhz);
    pressed = 16'h0000;
    reset = 1'b0;
    idle(3);
    check("s6_post_valid", kif.key_valid, 1'b0);
    check("s6_post_digits", kif.digits, 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
